c_frag_pipe: RTL and testbench

Parametrised, pipelined successor of the pp3 two-level mux logic fragment. It provides W-bit lanes through the same top/bottom input-inversion and three-stage mux tree, with two additions: configurable pipeline registers with a valid pipe, and a runtime-loadable inversion configuration. The inversion configuration is shifted in serially and applied atomically on commit. The block sits in the logic tile wherever a registered wide mux is needed, and it replaces chained C_FRAG and Q_FRAG pairs.

---
 rtl/c_frag_pipe_pkg.sv | 25 ++
 rtl/c_frag_pipe_if.sv | 29 ++
 rtl/c_frag_cfg_chain.sv | 80 ++++++++
 rtl/c_frag_pipe.sv | 160 ++++++++++++++++
 tb/tb_c_frag_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c_frag_pipe_pkg.sv
// Shared pp3 logic-fragment definitions: inversion-config bit map, word type
// and counter helpers used by the pipelined C_FRAG and its config chain.
package c_frag_pipe_pkg;

    localparam int CFG_WORD_BITS = 8;

    localparam int CFG_TAS1 = 0;
    localparam int CFG_TAS2 = 1;
    localparam int CFG_TBS1 = 2;
    localparam int CFG_TBS2 = 3;
    localparam int CFG_BAS1 = 4;
    localparam int CFG_BAS2 = 5;
    localparam int CFG_BBS1 = 6;
    localparam int CFG_BBS2 = 7;

    localparam int CFG_CNT_W = 4;
    localparam logic [CFG_CNT_W-1:0] CFG_CNT_FULL = 4'd8;

    typedef logic [CFG_WORD_BITS-1:0] inv_cfg_t;

    function automatic logic cnt_full(input logic [CFG_CNT_W-1:0] cnt);
        return (cnt == CFG_CNT_FULL);
    endfunction

endpackage

// File: rtl/c_frag_pipe_if.sv
// Data, select, valid and config-chain signals of one c_frag_pipe instance;
// the bench drives through master, the block attaches as slave.
interface c_frag_pipe_if #(parameter int W = 1);

    logic         QEN;
    logic         IVLD;
    logic         TBS, TAB, TSL, BAB, BSL;
    logic [W-1:0] TA1, TA2, TB1, TB2;
    logic [W-1:0] BA1, BA2, BB1, BB2;
    logic [W-1:0] TZ, CZ;
    logic         OVLD;
    logic         CFG_EN, CFG_DI, CFG_COMMIT;
    logic         CFG_RDY, CFG_ERR;

    modport master (
        output QEN, IVLD, TBS, TAB, TSL, BAB, BSL,
        output TA1, TA2, TB1, TB2, BA1, BA2, BB1, BB2,
        output CFG_EN, CFG_DI, CFG_COMMIT,
        input  TZ, CZ, OVLD, CFG_RDY, CFG_ERR
    );

    modport slave (
        input  QEN, IVLD, TBS, TAB, TSL, BAB, BSL,
        input  TA1, TA2, TB1, TB2, BA1, BA2, BB1, BB2,
        input  CFG_EN, CFG_DI, CFG_COMMIT,
        output TZ, CZ, OVLD, CFG_RDY, CFG_ERR
    );

endinterface

// File: rtl/c_frag_cfg_chain.sv
// Serial inversion-config loader: 8-bit shift register with saturating count,
// atomic commit into the active word, and a sticky error for early commits.
module c_frag_cfg_chain
    import c_frag_pipe_pkg::*;
#(
    parameter inv_cfg_t INV_INIT = 8'h00
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     en_i,
    input  logic     di_i,
    input  logic     commit_i,
    output inv_cfg_t active_o,
    output logic     rdy_o,
    output logic     err_o
);

    inv_cfg_t             sr_q, sr_d;
    inv_cfg_t             active_q, active_d;
    logic [CFG_CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;
    logic                 rdy_q, rdy_d;
    logic                 err_q, err_d;

    // Commit resolves against the pre-shift word; cnt_base_s is the count a
    // same-cycle shift then builds on.
    always_comb begin
        active_d   = active_q;
        err_d      = err_q;
        cnt_base_s = cnt_q;
        if (commit_i) begin
            if (rdy_q) begin
                active_d   = sr_q;
                cnt_base_s = '0;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            cnt_base_s = cnt_q;
        end
    end

    // Shift path with saturating bit count
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_base_s;
        if (en_i) begin
            sr_d = {di_i, sr_q[CFG_WORD_BITS-1:1]};
            if (cnt_full(cnt_base_s)) begin
                cnt_d = CFG_CNT_FULL;
            end else begin
                cnt_d = cnt_base_s + 4'd1;
            end
        end else begin
            cnt_d = cnt_base_s;
        end
        rdy_d = cnt_full(cnt_d);
    end

    // Config state registers, independent of the datapath enable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q     <= '0;
            active_q <= INV_INIT;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
        end
    end

    assign active_o = active_q;
    assign rdy_o    = rdy_q;
    assign err_o    = err_q;

endmodule

// File: rtl/c_frag_pipe.sv
// Pipelined W-lane C_FRAG: per-input inversion, three-level mux tree with
// PIPE (1..3) register stages, a matching valid pipe and a loadable config.
module c_frag_pipe
    import c_frag_pipe_pkg::*;
#(
    parameter int       W        = 1,
    parameter int       PIPE     = 1,
    parameter inv_cfg_t INV_INIT = 8'h00
) (
    input  logic         QCK,
    input  logic         QRT,
    c_frag_pipe_if.slave bus
);

    if ((PIPE < 1) || (PIPE > 3)) begin : g_bad_pipe
        $error("c_frag_pipe: PIPE must be in 1..3");
    end

    inv_cfg_t cfg_s;

    c_frag_cfg_chain #(.INV_INIT(INV_INIT)) u_cfg (
        .clk_i    (QCK),
        .rst_i    (QRT),
        .en_i     (bus.CFG_EN),
        .di_i     (bus.CFG_DI),
        .commit_i (bus.CFG_COMMIT),
        .active_o (cfg_s),
        .rdy_o    (bus.CFG_RDY),
        .err_o    (bus.CFG_ERR)
    );

    logic [W-1:0] ta1_s, ta2_s, tb1_s, tb2_s, ba1_s, ba2_s, bb1_s, bb2_s;
    logic [W-1:0] tai_s, tbi_s, bai_s, bbi_s;

    assign ta1_s = bus.TA1 ^ {W{cfg_s[CFG_TAS1]}};
    assign ta2_s = bus.TA2 ^ {W{cfg_s[CFG_TAS2]}};
    assign tb1_s = bus.TB1 ^ {W{cfg_s[CFG_TBS1]}};
    assign tb2_s = bus.TB2 ^ {W{cfg_s[CFG_TBS2]}};
    assign ba1_s = bus.BA1 ^ {W{cfg_s[CFG_BAS1]}};
    assign ba2_s = bus.BA2 ^ {W{cfg_s[CFG_BAS2]}};
    assign bb1_s = bus.BB1 ^ {W{cfg_s[CFG_BBS1]}};
    assign bb2_s = bus.BB2 ^ {W{cfg_s[CFG_BBS2]}};

    assign tai_s = bus.TSL ? ta2_s : ta1_s;
    assign tbi_s = bus.TSL ? tb2_s : tb1_s;
    assign bai_s = bus.BSL ? ba2_s : ba1_s;
    assign bbi_s = bus.BSL ? bb2_s : bb1_s;

    // Stage A outputs: first-level mux results plus the selects still needed
    logic [W-1:0] tai_a_s, tbi_a_s, bai_a_s, bbi_a_s;
    logic         tab_a_s, bab_a_s, tbs_a_s;

    if (PIPE == 3) begin : g_stage_a
        logic [W-1:0] tai_q, tbi_q, bai_q, bbi_q;
        logic         tab_q, bab_q, tbs_q;

        // Registers after the first mux level, selects travel with their data
        always_ff @(posedge QCK or posedge QRT) begin
            if (QRT) begin
                tai_q <= '0;
                tbi_q <= '0;
                bai_q <= '0;
                bbi_q <= '0;
                tab_q <= 1'b0;
                bab_q <= 1'b0;
                tbs_q <= 1'b0;
            end else if (bus.QEN) begin
                tai_q <= tai_s;
                tbi_q <= tbi_s;
                bai_q <= bai_s;
                bbi_q <= bbi_s;
                tab_q <= bus.TAB;
                bab_q <= bus.BAB;
                tbs_q <= bus.TBS;
            end
        end

        assign tai_a_s = tai_q;
        assign tbi_a_s = tbi_q;
        assign bai_a_s = bai_q;
        assign bbi_a_s = bbi_q;
        assign tab_a_s = tab_q;
        assign bab_a_s = bab_q;
        assign tbs_a_s = tbs_q;
    end else begin : g_stage_a_bypass
        assign tai_a_s = tai_s;
        assign tbi_a_s = tbi_s;
        assign bai_a_s = bai_s;
        assign bbi_a_s = bbi_s;
        assign tab_a_s = bus.TAB;
        assign bab_a_s = bus.BAB;
        assign tbs_a_s = bus.TBS;
    end

    logic [W-1:0] tzi_s, bzi_s;
    assign tzi_s = tab_a_s ? tbi_a_s : tai_a_s;
    assign bzi_s = bab_a_s ? bbi_a_s : bai_a_s;

    logic [W-1:0] tzi_b_s, bzi_b_s;
    logic         tbs_b_s;

    if (PIPE >= 2) begin : g_stage_b
        logic [W-1:0] tzi_q, bzi_q;
        logic         tbs_q;

        // Registers after the second mux level
        always_ff @(posedge QCK or posedge QRT) begin
            if (QRT) begin
                tzi_q <= '0;
                bzi_q <= '0;
                tbs_q <= 1'b0;
            end else if (bus.QEN) begin
                tzi_q <= tzi_s;
                bzi_q <= bzi_s;
                tbs_q <= tbs_a_s;
            end
        end

        assign tzi_b_s = tzi_q;
        assign bzi_b_s = bzi_q;
        assign tbs_b_s = tbs_q;
    end else begin : g_stage_b_bypass
        assign tzi_b_s = tzi_s;
        assign bzi_b_s = bzi_s;
        assign tbs_b_s = tbs_a_s;
    end

    logic [W-1:0] czi_s;
    assign czi_s = tbs_b_s ? bzi_b_s : tzi_b_s;

    logic [W-1:0] tz_q, cz_q;
    logic [PIPE-1:0] vld_q, vld_d;

    // Valid pipe is exactly PIPE flops deep so OVLD lines up with TZ/CZ
    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = bus.IVLD;
        for (int i = 1; i < PIPE; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Output and valid registers
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            tz_q  <= '0;
            cz_q  <= '0;
            vld_q <= '0;
        end else if (bus.QEN) begin
            tz_q  <= tzi_b_s;
            cz_q  <= czi_s;
            vld_q <= vld_d;
        end
    end

    assign bus.TZ   = tz_q;
    assign bus.CZ   = cz_q;
    assign bus.OVLD = vld_q[PIPE-1];

endmodule

// File: tb/tb_c_frag_pipe.sv
// Directed bench for c_frag_pipe: three instances (PIPE=1/2/3) sharing one
// clock and reset, each scenario in its own task with inline checks.
module tb_c_frag_pipe;
    import c_frag_pipe_pkg::*;

    logic QCK = 1'b0;
    logic QRT = 1'b0;
    always #5 QCK = ~QCK;

    c_frag_pipe_if #(.W(4)) if1 ();
    c_frag_pipe_if #(.W(1)) if2 ();
    c_frag_pipe_if #(.W(1)) if3 ();

    c_frag_pipe #(.W(4), .PIPE(1), .INV_INIT(8'h01)) u_p1 (.QCK(QCK), .QRT(QRT), .bus(if1));
    c_frag_pipe #(.W(1), .PIPE(2), .INV_INIT(8'h00)) u_p2 (.QCK(QCK), .QRT(QRT), .bus(if2));
    c_frag_pipe #(.W(1), .PIPE(3), .INV_INIT(8'h00)) u_p3 (.QCK(QCK), .QRT(QRT), .bus(if3));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic tbs, tab, tsl, bab, bsl;
        logic ta1, ta2, tb1, tb2, ba1, ba2, bb1, bb2;
        logic ivld;
    } vec_t;

    // Reference C_FRAG for one lane: returns {TZ, CZ}
    function automatic logic [1:0] cfrag_model(input logic [7:0] cfg, input vec_t v);
        logic tai, tbi, bai, bbi, tz, bz, cz;
        tai = v.tsl ? (v.ta2 ^ cfg[1]) : (v.ta1 ^ cfg[0]);
        tbi = v.tsl ? (v.tb2 ^ cfg[3]) : (v.tb1 ^ cfg[2]);
        bai = v.bsl ? (v.ba2 ^ cfg[5]) : (v.ba1 ^ cfg[4]);
        bbi = v.bsl ? (v.bb2 ^ cfg[7]) : (v.bb1 ^ cfg[6]);
        tz  = v.tab ? tbi : tai;
        bz  = v.bab ? bbi : bai;
        cz  = v.tbs ? bz : tz;
        return {tz, cz};
    endfunction

    task automatic tick();
        @(posedge QCK);
        #1;
    endtask

    task automatic clear_inputs();
        {if1.QEN, if1.IVLD, if1.TBS, if1.TAB, if1.TSL, if1.BAB, if1.BSL, if1.CFG_EN, if1.CFG_DI, if1.CFG_COMMIT} = 10'b1000000000;
        {if1.TA1, if1.TA2, if1.TB1, if1.TB2, if1.BA1, if1.BA2, if1.BB1, if1.BB2} = 32'h0;
        {if2.QEN, if2.IVLD, if2.TBS, if2.TAB, if2.TSL, if2.BAB, if2.BSL, if2.CFG_EN, if2.CFG_DI, if2.CFG_COMMIT} = 10'b1000000000;
        {if2.TA1, if2.TA2, if2.TB1, if2.TB2, if2.BA1, if2.BA2, if2.BB1, if2.BB2} = 8'h0;
        {if3.QEN, if3.IVLD, if3.TBS, if3.TAB, if3.TSL, if3.BAB, if3.BSL, if3.CFG_EN, if3.CFG_DI, if3.CFG_COMMIT} = 10'b1000000000;
        {if3.TA1, if3.TA2, if3.TB1, if3.TB2, if3.BA1, if3.BA2, if3.BB1, if3.BB2} = 8'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        QRT = 1'b1;
        tick();
        tick();
        QRT = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({if1.TZ, if1.CZ, if1.OVLD, if1.CFG_RDY, if1.CFG_ERR} !== 11'h0) begin
            n_bad++; $display("FAIL reset_p1: got %0h want 0", {if1.TZ, if1.CZ, if1.OVLD, if1.CFG_RDY, if1.CFG_ERR});
        end
        n_cmp++;
        if ({if2.TZ, if2.CZ, if2.OVLD, if2.CFG_RDY, if2.CFG_ERR} !== 5'h0) begin
            n_bad++; $display("FAIL reset_p2: got %0h want 0", {if2.TZ, if2.CZ, if2.OVLD, if2.CFG_RDY, if2.CFG_ERR});
        end
        n_cmp++;
        if ({if3.TZ, if3.CZ, if3.OVLD, if3.CFG_RDY, if3.CFG_ERR} !== 5'h0) begin
            n_bad++; $display("FAIL reset_p3: got %0h want 0", {if3.TZ, if3.CZ, if3.OVLD, if3.CFG_RDY, if3.CFG_ERR});
        end
    endtask

    task automatic test_pipe1_inv();
        do_reset();
        if1.TA1  = 4'b0011;
        if1.IVLD = 1'b1;
        tick();
        n_cmp++;
        if ({if1.TZ, if1.CZ, if1.OVLD} !== {4'b1100, 4'b1100, 1'b1}) begin
            n_bad++; $display("FAIL p1_inv_ta1: got %0h want %0h", {if1.TZ, if1.CZ, if1.OVLD}, {4'b1100, 4'b1100, 1'b1});
        end
        if1.TBS  = 1'b1;
        if1.BAB  = 1'b1;
        if1.BSL  = 1'b1;
        if1.BB2  = 4'b1010;
        if1.IVLD = 1'b0;
        tick();
        n_cmp++;
        if ({if1.TZ, if1.CZ, if1.OVLD} !== {4'b1100, 4'b1010, 1'b0}) begin
            n_bad++; $display("FAIL p1_bottom_bb2: got %0h want %0h", {if1.TZ, if1.CZ, if1.OVLD}, {4'b1100, 4'b1010, 1'b0});
        end
    endtask

    task automatic test_pipe3_stream();
        vec_t        vq [12];
        logic [31:0] r;
        logic [1:0]  exp;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            r = $urandom();
            vq[i] = (i < 10) ? r[$bits(vec_t)-1:0] : '0;
            if (i < 10) vq[i].ivld = i[0];
            {if3.TBS, if3.TAB, if3.TSL, if3.BAB, if3.BSL, if3.TA1, if3.TA2, if3.TB1, if3.TB2,
             if3.BA1, if3.BA2, if3.BB1, if3.BB2, if3.IVLD} = vq[i];
            tick();
            if (i >= 2) begin
                exp = cfrag_model(8'h00, vq[i-2]);
                n_cmp++;
                if ({if3.TZ, if3.CZ, if3.OVLD} !== {exp, vq[i-2].ivld}) begin
                    n_bad++; $display("FAIL p3_stream[%0d]: got %0b want %0b", i, {if3.TZ, if3.CZ, if3.OVLD}, {exp, vq[i-2].ivld});
                end
            end else begin
                n_cmp++;
                if (if3.OVLD !== 1'b0) begin
                    n_bad++; $display("FAIL p3_fill_ovld[%0d]: got %0b want 0", i, if3.OVLD);
                end
            end
        end
    endtask

    task automatic test_cfg_commit();
        do_reset();
        if2.CFG_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if2.CFG_DI = (i == 0);
            tick();
            if (i == 6) begin
                n_cmp++;
                if (if2.CFG_RDY !== 1'b0) begin
                    n_bad++; $display("FAIL cfg_rdy_7: got %0b want 0", if2.CFG_RDY);
                end
            end
        end
        n_cmp++;
        if (if2.CFG_RDY !== 1'b1) begin
            n_bad++; $display("FAIL cfg_rdy_8: got %0b want 1", if2.CFG_RDY);
        end
        if2.CFG_EN     = 1'b0;
        if2.CFG_COMMIT = 1'b1;
        if2.TA1        = 1'b1;
        if2.IVLD       = 1'b1;
        tick();
        if2.CFG_COMMIT = 1'b0;
        n_cmp++;
        if (if2.CFG_RDY !== 1'b0) begin
            n_bad++; $display("FAIL cfg_rdy_after_commit: got %0b want 0", if2.CFG_RDY);
        end
        tick();
        n_cmp++;
        if ({if2.TZ, if2.CZ} !== 2'b11) begin
            n_bad++; $display("FAIL cfg_commit_edge_old: got %0b want 11", {if2.TZ, if2.CZ});
        end
        tick();
        n_cmp++;
        if ({if2.TZ, if2.CZ} !== 2'b00) begin
            n_bad++; $display("FAIL cfg_after_commit_new: got %0b want 00", {if2.TZ, if2.CZ});
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        if2.TA1    = 1'b1;
        if2.CFG_EN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if2.CFG_DI = (i == 0);
            tick();
        end
        if2.CFG_EN     = 1'b0;
        if2.CFG_COMMIT = 1'b1;
        tick();
        if2.CFG_COMMIT = 1'b0;
        n_cmp++;
        if (if2.CFG_ERR !== 1'b0) begin
            n_bad++; $display("FAIL err_valid_commit: got %0b want 0", if2.CFG_ERR);
        end
        if2.CFG_EN = 1'b1;
        if2.CFG_DI = 1'b0;
        repeat (5) tick();
        if2.CFG_EN     = 1'b0;
        if2.CFG_COMMIT = 1'b1;
        tick();
        if2.CFG_COMMIT = 1'b0;
        n_cmp++;
        if ({if2.CFG_ERR, if2.CFG_RDY} !== 2'b10) begin
            n_bad++; $display("FAIL err_early_commit: got %0b want 10", {if2.CFG_ERR, if2.CFG_RDY});
        end
        tick();
        tick();
        n_cmp++;
        if (if2.TZ !== 1'b0) begin
            n_bad++; $display("FAIL err_cfg_unchanged: got %0b want 0", if2.TZ);
        end
        if2.CFG_EN = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (if2.CFG_RDY !== 1'b1) begin
            n_bad++; $display("FAIL err_cnt_kept: got %0b want 1", if2.CFG_RDY);
        end
        if2.CFG_COMMIT = 1'b1;
        tick();
        if2.CFG_COMMIT = 1'b0;
        if2.CFG_EN     = 1'b0;
        n_cmp++;
        if ({if2.CFG_ERR, if2.CFG_RDY} !== 2'b10) begin
            n_bad++; $display("FAIL err_sticky: got %0b want 10", {if2.CFG_ERR, if2.CFG_RDY});
        end
        tick();
        tick();
        n_cmp++;
        if (if2.TZ !== 1'b1) begin
            n_bad++; $display("FAIL err_new_cfg: got %0b want 1", if2.TZ);
        end
        if2.CFG_EN = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (if2.CFG_RDY !== 1'b0) begin
            n_bad++; $display("FAIL commit_shift_cnt7: got %0b want 0", if2.CFG_RDY);
        end
        tick();
        n_cmp++;
        if ({if2.CFG_RDY, if2.CFG_ERR} !== 2'b11) begin
            n_bad++; $display("FAIL commit_shift_cnt8: got %0b want 11", {if2.CFG_RDY, if2.CFG_ERR});
        end
        do_reset();
        n_cmp++;
        if (if2.CFG_ERR !== 1'b0) begin
            n_bad++; $display("FAIL err_cleared_by_reset: got %0b want 0", if2.CFG_ERR);
        end
    endtask

    task automatic test_qen_hold();
        logic s_ta, s_ba, s_v, o_ta, o_ba, o_v;
        logic qen;
        do_reset();
        {s_ta, s_ba, s_v, o_ta, o_ba, o_v} = 6'b0;
        if2.TBS = 1'b1;
        for (int i = 0; i < 14; i++) begin
            qen      = !((i >= 5) && (i <= 7));
            if2.TA1  = i[0];
            if2.BA1  = i[1];
            if2.IVLD = (i % 3) != 0;
            if2.QEN  = qen;
            tick();
            if (qen) begin
                {o_ta, o_ba, o_v} = {s_ta, s_ba, s_v};
                {s_ta, s_ba, s_v} = {if2.TA1, if2.BA1, if2.IVLD};
            end
            n_cmp++;
            if ({if2.TZ, if2.CZ, if2.OVLD} !== {o_ta, o_ba, o_v}) begin
                n_bad++; $display("FAIL qen_stream[%0d]: got %0b want %0b", i, {if2.TZ, if2.CZ, if2.OVLD}, {o_ta, o_ba, o_v});
            end
        end
        if2.QEN = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        if1.CFG_EN = 1'b1;
        if1.CFG_DI = 1'b0;
        repeat (8) tick();
        if1.CFG_EN     = 1'b0;
        if1.CFG_COMMIT = 1'b1;
        tick();
        if1.CFG_COMMIT = 1'b0;
        if1.CFG_EN     = 1'b1;
        repeat (4) tick();
        if1.TA1  = 4'b0011;
        if1.IVLD = 1'b1;
        tick();
        if1.CFG_EN = 1'b0;
        n_cmp++;
        if ({if1.TZ, if1.CZ, if1.OVLD} !== {4'b0011, 4'b0011, 1'b1}) begin
            n_bad++; $display("FAIL ar_pre: got %0h want %0h", {if1.TZ, if1.CZ, if1.OVLD}, {4'b0011, 4'b0011, 1'b1});
        end
        #2;
        QRT = 1'b1;
        #1;
        n_cmp++;
        if ({if1.TZ, if1.CZ, if1.OVLD, if1.CFG_RDY} !== 10'h0) begin
            n_bad++; $display("FAIL ar_immediate: got %0h want 0", {if1.TZ, if1.CZ, if1.OVLD, if1.CFG_RDY});
        end
        #1;
        QRT      = 1'b0;
        if1.IVLD = 1'b0;
        tick();
        n_cmp++;
        if ({if1.TZ, if1.OVLD} !== {4'b1100, 1'b0}) begin
            n_bad++; $display("FAIL ar_release: got %0h want %0h", {if1.TZ, if1.OVLD}, {4'b1100, 1'b0});
        end
        if1.CFG_EN = 1'b1;
        repeat (3) tick();
        if1.CFG_EN = 1'b0;
        n_cmp++;
        if (if1.CFG_RDY !== 1'b0) begin
            n_bad++; $display("FAIL ar_partial_dropped: got %0b want 0", if1.CFG_RDY);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_pipe1_inv();
        test_pipe3_stream();
        test_cfg_commit();
        test_cfg_err();
        test_qen_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
